// File: rtl/rv32_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control unit.
package rv32_ctrl_pkg;

  // Major opcodes recognised by the control unit
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_IALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  // Only word-sized loads and stores are supported
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_sel_e;

  typedef enum logic [1:0] {
    WB_MEM  = 2'd0,
    WB_ALU  = 2'd1,
    WB_PC4  = 2'd2,
    WB_UIMM = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_e;

  // funct3 to ALU operation; alt selects SUB for 000 and SRA for 101
  function automatic alu_sel_e funct3_to_alu(input logic [2:0] f3, input logic alt);
    alu_sel_e sel;
    sel = ALU_ADD;
    case (f3)
      3'b000: sel = alt ? ALU_SUB : ALU_ADD;
      3'b001: sel = ALU_SLL;
      3'b010: sel = ALU_SLT;
      3'b011: sel = ALU_SLTU;
      3'b100: sel = ALU_XOR;
      3'b101: sel = alt ? ALU_SRA : ALU_SRL;
      3'b110: sel = ALU_OR;
      3'b111: sel = ALU_AND;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction classifier: ALU operation, operand source,
// write-back source and legality for the supported RV32I subset.
module alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  input  logic       funct7_rest_zero_i,  // funct7 bits other than bit 5 are all zero
  output alu_sel_e   alu_sel_o,
  output logic       alu_src_o,
  output wb_sel_e    wb_sel_o,
  output logic       legal_o
);

  // Decode opcode/funct fields into control values and a legality flag
  always_comb begin
    alu_sel_o = ALU_ADD;
    alu_src_o = 1'b0;
    wb_sel_o  = WB_ALU;
    legal_o   = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        // funct7 0x20 is only meaningful for SUB and SRA
        legal_o   = funct7_rest_zero_i &&
                    (!funct7_b5_i || funct3_i == 3'b000 || funct3_i == 3'b101);
        alu_sel_o = funct3_to_alu(funct3_i, funct7_b5_i);
        alu_src_o = 1'b0;
      end
      OPC_IALU: begin
        // Only the shift forms carry funct7; elsewhere those bits are immediate
        case (funct3_i)
          3'b001:  legal_o = funct7_rest_zero_i && !funct7_b5_i;
          3'b101:  legal_o = funct7_rest_zero_i;
          default: legal_o = 1'b1;
        endcase
        alu_sel_o = funct3_to_alu(funct3_i, funct7_b5_i && (funct3_i == 3'b101));
        alu_src_o = 1'b1;
      end
      OPC_LOAD: begin
        legal_o   = (funct3_i == F3_WORD);
        alu_src_o = 1'b1;
        wb_sel_o  = WB_MEM;
      end
      OPC_STORE: begin
        legal_o   = (funct3_i == F3_WORD);
        alu_src_o = 1'b1;
      end
      OPC_LUI: begin
        legal_o   = 1'b1;
        alu_src_o = 1'b1;
        wb_sel_o  = WB_UIMM;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving data_path controls.
module ctrl_fsm
  import rv32_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] instr,
  input  logic            mem_ready,
  output logic            en_pc,
  output logic            RegWrite,
  output logic            AluSrc,
  output logic [3:0]      AluSel,
  output logic            Mem_read,
  output logic            Mem_write,
  output logic [1:0]      sel_data_to_reg,
  output logic            illegal_instr,
  output logic [XLEN-1:0] instret
);

  ctrl_state_e     state_q, state_d;
  logic [6:0]      ir_opcode_q;
  logic [2:0]      ir_funct3_q;
  logic            ir_f7b5_q;
  logic            illegal_q;
  logic [XLEN-1:0] instret_q;

  // Decoder looks at the live instruction in DECODE (for legality) and at IR otherwise
  logic [6:0] dec_opcode;
  logic [2:0] dec_funct3;
  logic       dec_f7b5;
  logic       dec_f7_rest_zero;
  alu_sel_e   dec_alu_sel;
  logic       dec_alu_src;
  wb_sel_e    dec_wb_sel;
  logic       dec_legal;

  // Register, immediate and funct7 bits beyond bit 5 never reach IR
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign dec_opcode       = (state_q == ST_DECODE) ? instr[6:0]   : ir_opcode_q;
  assign dec_funct3       = (state_q == ST_DECODE) ? instr[14:12] : ir_funct3_q;
  assign dec_f7b5         = (state_q == ST_DECODE) ? instr[30]    : ir_f7b5_q;
  assign dec_f7_rest_zero = (state_q == ST_DECODE) ?
                            ({instr[31], instr[29:25]} == 6'd0) : 1'b1;

  alu_decoder u_alu_decoder (
    .opcode_i           (dec_opcode),
    .funct3_i           (dec_funct3),
    .funct7_b5_i        (dec_f7b5),
    .funct7_rest_zero_i (dec_f7_rest_zero),
    .alu_sel_o          (dec_alu_sel),
    .alu_src_o          (dec_alu_src),
    .wb_sel_o           (dec_wb_sel),
    .legal_o            (dec_legal)
  );

  logic ir_is_load, ir_is_store;
  assign ir_is_load  = (ir_opcode_q == OPC_LOAD);
  assign ir_is_store = (ir_opcode_q == OPC_STORE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  // IR capture, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_opcode_q <= '0;
      ir_funct3_q <= '0;
      ir_f7b5_q   <= 1'b0;
      illegal_q   <= 1'b0;
      instret_q   <= '0;
    end else begin
      if (state_q == ST_DECODE) begin
        ir_opcode_q <= instr[6:0];
        ir_funct3_q <= instr[14:12];
        ir_f7b5_q   <= instr[30];
        if (!dec_legal) illegal_q <= 1'b1;
      end
      if (state_q == ST_WB) instret_q <= instret_q + 1'b1;
    end
  end

  logic       en_pc_d, reg_write_d, alu_src_d, mem_read_d, mem_write_d;
  logic [3:0] alu_sel_d;
  logic [1:0] wb_sel_d;

  // Next-state and Moore control decode
  always_comb begin
    state_d     = state_q;
    en_pc_d     = 1'b0;
    reg_write_d = 1'b0;
    alu_src_d   = 1'b0;
    alu_sel_d   = 4'd0;
    wb_sel_d    = 2'd0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        alu_src_d = dec_alu_src;
        alu_sel_d = dec_alu_sel;
        wb_sel_d  = dec_wb_sel;
        state_d   = (ir_is_load || ir_is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        alu_src_d   = dec_alu_src;
        alu_sel_d   = dec_alu_sel;
        wb_sel_d    = dec_wb_sel;
        mem_read_d  = ir_is_load;
        mem_write_d = ir_is_store;
        if (mem_ready) state_d = ST_WB;
      end
      ST_WB: begin
        alu_src_d   = dec_alu_src;
        alu_sel_d   = dec_alu_sel;
        wb_sel_d    = dec_wb_sel;
        en_pc_d     = 1'b1;
        reg_write_d = !ir_is_store;
        state_d     = ST_FETCH;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Controls are forced low while reset is asserted so an aborted MEM
  // access never strobes memory in the reset cycle
  assign en_pc           = reset_n & en_pc_d;
  assign RegWrite        = reset_n & reg_write_d;
  assign AluSrc          = reset_n & alu_src_d;
  assign AluSel          = reset_n ? alu_sel_d : 4'd0;
  assign Mem_read        = reset_n & mem_read_d;
  assign Mem_write       = reset_n & mem_write_d;
  assign sel_data_to_reg = reset_n ? wb_sel_d : 2'd0;
  assign illegal_instr   = illegal_q;
  assign instret         = instret_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: directed instructions push expected WB and
// memory-strobe records; a negedge monitor pops and compares them.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        en_pc, RegWrite, AluSrc, Mem_read, Mem_write, illegal_instr;
  logic [3:0]  AluSel;
  logic [1:0]  sel_data_to_reg;
  logic [31:0] instret;

  always #5 clk = ~clk;

  ctrl_fsm #(.XLEN(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr           (instr),
    .mem_ready       (mem_ready),
    .en_pc           (en_pc),
    .RegWrite        (RegWrite),
    .AluSrc          (AluSrc),
    .AluSel          (AluSel),
    .Mem_read        (Mem_read),
    .Mem_write       (Mem_write),
    .sel_data_to_reg (sel_data_to_reg),
    .illegal_instr   (illegal_instr),
    .instret         (instret)
  );

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int stall_n = 0;

  typedef struct {
    logic        rw;
    logic        src;
    logic [3:0]  alu;
    logic [1:0]  wb;
    logic [31:0] cnt;
    string       name;
  } wb_exp_t;

  typedef struct {
    logic  rd;
    logic  wr;
    int    cycles;
    string name;
  } mem_exp_t;

  wb_exp_t  wbq[$];
  mem_exp_t memq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_bits();
    return {en_pc, RegWrite, AluSrc, AluSel, Mem_read, Mem_write, sel_data_to_reg};
  endfunction

  // Memory model: holds mem_ready low for stall_n strobe cycles, then completes
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (Mem_read || Mem_write) begin
        if (stall_cnt < stall_n) begin
          mem_ready = 1'b0;
          stall_cnt++;
        end else begin
          mem_ready = 1'b1;
        end
      end else begin
        stall_cnt = 0;
        mem_ready = (stall_n == 0);
      end
    end
  end

  // Monitor: compares WB cycles and completed memory-strobe runs against the queues
  initial begin
    int       run_len;
    logic     run_rd, run_wr, run_alu_bad;
    wb_exp_t  w;
    mem_exp_t m;
    run_len = 0;
    run_rd = 1'b0;
    run_wr = 1'b0;
    run_alu_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (en_pc) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", 32'd1, 32'd0);
        end else begin
          w = wbq.pop_front();
          chk({w.name, "_RegWrite"}, RegWrite, w.rw);
          chk({w.name, "_AluSrc"}, AluSrc, w.src);
          chk({w.name, "_AluSel"}, AluSel, w.alu);
          chk({w.name, "_sel_data_to_reg"}, sel_data_to_reg, w.wb);
          chk({w.name, "_instret_in_wb"}, instret, w.cnt);
          $display("WB   %s RegWrite=%0d AluSrc=%0d AluSel=%0d sel=%0d instret=%0d",
                   w.name, RegWrite, AluSrc, AluSel, sel_data_to_reg, instret);
        end
      end
      if (RegWrite) chk("regwrite_only_in_wb", en_pc, 1'b1);
      if (Mem_read || Mem_write) begin
        if (run_len == 0) begin
          run_rd = Mem_read;
          run_wr = Mem_write;
          run_alu_bad = 1'b0;
        end
        if (AluSel != 4'd0 || Mem_read !== run_rd || Mem_write !== run_wr) run_alu_bad = 1'b1;
        run_len++;
      end else if (run_len > 0) begin
        if (memq.size() == 0) begin
          chk("mem_unexpected", 32'd1, 32'd0);
        end else begin
          m = memq.pop_front();
          chk({m.name, "_mem_cycles"}, run_len, m.cycles);
          chk({m.name, "_Mem_read"}, run_rd, m.rd);
          chk({m.name, "_Mem_write"}, run_wr, m.wr);
          chk({m.name, "_mem_stable_add"}, run_alu_bad, 1'b0);
          $display("MEM  %s rd=%0d wr=%0d cycles=%0d", m.name, run_rd, run_wr, run_len);
        end
        run_len = 0;
      end
    end
  end

  // Issue one instruction from FETCH; called at posedge+1 with the FSM in FETCH
  task automatic run_instr(input string name, input logic [31:0] ins, input int stall,
                           input logic rw, input logic src, input logic [3:0] alu,
                           input logic [1:0] wb, input int lat, input logic rd, input logic wr);
    wb_exp_t  w;
    mem_exp_t m;
    int       cyc;
    w.rw = rw; w.src = src; w.alu = alu; w.wb = wb; w.cnt = exp_cnt; w.name = name;
    wbq.push_back(w);
    if (rd || wr) begin
      m.rd = rd; m.wr = wr; m.cycles = stall + 1; m.name = name;
      memq.push_back(m);
    end
    stall_n = stall;
    instr = ins;
    cyc = 1;
    while (!en_pc && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_wb_reached"}, en_pc, 1'b1);
    chk({name, "_latency"}, cyc, lat);
    exp_cnt++;
    @(posedge clk); #1;
    instr = 32'hFFFF_FFFF;
    chk({name, "_instret"}, instret, exp_cnt);
  endtask

  // Load whose MEM wait is cut short by reset
  task automatic reset_mid_mem();
    mem_exp_t m;
    int       cyc;
    m.rd = 1'b1; m.wr = 1'b0; m.cycles = 2; m.name = "lw_reset";
    memq.push_back(m);
    stall_n = 100;
    instr = 32'h0000A183;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!Mem_read && cyc < 20);
    chk("lw_reset_mem_reached", Mem_read, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("lw_reset_no_strobe_in_reset", {Mem_read, Mem_write}, 2'b00);
    @(posedge clk); #1;
    chk("lw_reset_outputs", ctrl_bits(), 11'd0);
    chk("lw_reset_instret", instret, 32'd0);
    chk("lw_reset_illegal", illegal_instr, 1'b0);
    reset_n = 1'b1;
    exp_cnt = 0;
    stall_n = 0;
    $display("RST  lw_reset outputs=0x%0h instret=%0d", ctrl_bits(), instret);
  endtask

  // Illegal instruction: HALT with no controls for hold cycles, then reset
  task automatic run_illegal(input string name, input logic [31:0] ins, input int hold);
    logic bad;
    instr = ins;
    @(posedge clk); #1;
    @(posedge clk); #1;
    instr = 32'h00A00093;
    chk({name, "_illegal_set"}, illegal_instr, 1'b1);
    bad = 1'b0;
    repeat (hold) begin
      if (ctrl_bits() != 11'd0 || illegal_instr !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk({name, "_halt_quiet"}, bad, 1'b0);
    chk({name, "_halt_instret"}, instret, exp_cnt);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk({name, "_reset_clears_flag"}, illegal_instr, 1'b0);
    chk({name, "_reset_instret"}, instret, 32'd0);
    reset_n = 1'b1;
    exp_cnt = 0;
    $display("ILL  %s instr=0x%08h halted %0d cycles", name, ins, hold);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", ctrl_bits(), 11'd0);
    chk("reset_instret", instret, 32'd0);
    chk("reset_illegal", illegal_instr, 1'b0);
    reset_n = 1'b1;
    exp_cnt = 0;

    //         name    instr          stall rw  src alu    wb    lat rd  wr
    run_instr("addi", 32'h00A00093, 0, 1'b1, 1'b1, 4'd0, 2'd1, 4, 1'b0, 1'b0);
    run_instr("lui",  32'hABCDE2B7, 0, 1'b1, 1'b1, 4'd0, 2'd3, 4, 1'b0, 1'b0);
    run_instr("or",   32'h0050EA33, 0, 1'b1, 1'b0, 4'd3, 2'd1, 4, 1'b0, 1'b0);
    run_instr("sub",  32'h402080B3, 0, 1'b1, 1'b0, 4'd1, 2'd1, 4, 1'b0, 1'b0);
    run_instr("srai", 32'h4041D193, 0, 1'b1, 1'b1, 4'd7, 2'd1, 4, 1'b0, 1'b0);
    run_instr("sltu", 32'h0020B1B3, 0, 1'b1, 1'b0, 4'd9, 2'd1, 4, 1'b0, 1'b0);
    run_instr("xori", 32'h0FF0C093, 0, 1'b1, 1'b1, 4'd4, 2'd1, 4, 1'b0, 1'b0);
    run_instr("sw",   32'h0140A023, 2, 1'b0, 1'b1, 4'd0, 2'd1, 7, 1'b0, 1'b1);
    run_instr("lw",   32'h0000A183, 0, 1'b1, 1'b1, 4'd0, 2'd0, 5, 1'b1, 1'b0);
    run_instr("lw3",  32'h0000A183, 3, 1'b1, 1'b1, 4'd0, 2'd0, 8, 1'b1, 1'b0);

    reset_mid_mem();
    run_instr("addi_after_rst", 32'h00A00093, 0, 1'b1, 1'b1, 4'd0, 2'd1, 4, 1'b0, 1'b0);

    run_illegal("zero",       32'h00000000, 20);
    run_illegal("and_f7_20",  32'h4000F033, 5);
    run_illegal("load_f3_3",  32'h0000B003, 5);
    run_illegal("slli_f7_20", 32'h40001013, 5);
    run_instr("addi_resume", 32'h00A00093, 0, 1'b1, 1'b1, 4'd0, 2'd1, 4, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("wb_queue_drained", wbq.size(), 32'd0);
    chk("mem_queue_drained", memq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
